line_memory: RTL

//   Off-chip data memory model/controller sitting directly downstream of dcache_top.

---
 rtl/line_memory.sv | 138 +++++++++++++
 1 files changed

// File: rtl/line_memory.sv
// Line-granular backing memory behind the data cache: fixed-latency req/ack,
// one request in flight. Optional protocol checker via LINE_MEMORY_PROTO_CHK_EN.
module line_memory #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef LINE_MEMORY_PROTO_CHK_EN
  ,
  output logic              err_o
`endif
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic               accept_s;
  logic               done_s;
  logic [IDX_W-1:0]   idx_r;
  logic               write_r;
  logic [LINE_W-1:0]  wdata_r;
  logic [LINE_W-1:0]  mem_r [DEPTH];

  // Next-state logic; the completion edge is the one leaving ACK, so ack_o
  // lands LATENCY edges after accept and the ACK cycle itself ignores enable_i.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable_i) begin
          accept_s = 1'b1;
          cnt_s    = CNT_INIT;
          state_s  = BUSY;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY: begin
        cnt_s = cnt_r - 6'd1;
        if (cnt_r == 6'd1) begin
          state_s = ACK;
        end else begin
          state_s = BUSY;
        end
      end
      ACK: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state, request latch and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
      ack_o   <= 1'b0;
      data_o  <= '0;
      idx_r   <= '0;
      write_r <= 1'b0;
      wdata_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_o   <= done_s;
      if (accept_s) begin
        idx_r   <= addr_i[OFF_W+IDX_W-1:OFF_W];
        write_r <= write_i;
        wdata_r <= data_i;
      end
      if (done_s && !write_r) begin
        data_o <= mem_r[idx_r];
      end
    end
  end

  // Line storage; never cleared, and a reset before completion drops the write.
  always_ff @(posedge clk_i) begin
    if (rst_i && done_s && write_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

`ifdef LINE_MEMORY_PROTO_CHK_EN
  logic [ADDR_W-1:0] addr_r;

  // Full request address kept only for the stability check.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      addr_r <= '0;
    end else if (accept_s) begin
      addr_r <= addr_i;
    end
  end

  // Sticky protocol error: requester must hold its request stable while BUSY.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else if (state_r == BUSY &&
                 (!enable_i || (write_i != write_r) || (addr_i != addr_r))) begin
      err_o <= 1'b1;
    end
  end
`else
  logic unused_addr_s;
  assign unused_addr_s = ^{addr_i[OFF_W-1:0], addr_i[ADDR_W-1:OFF_W+IDX_W]};
`endif

endmodule
